// File: rtl/memoria_pkg.sv
// Shared types and helpers for the memoria_sync data memory.
// Holds the sequencer state type, a log2 helper and byte-lane constants.
package memoria_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int BYTE_W         = 8;
  localparam int DATA_W_DEFAULT = 8;
  localparam int BYTES          = DATA_W_DEFAULT / BYTE_W;

  // Address width for a memory of the given depth; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/memoria_sync_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// The read register only updates on a read, so it holds its value while a response waits.
module memoria_sync_ram
  import memoria_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 512,
  parameter int NB     = BYTES,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [NB-1:0]     we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we[b]) mem[addr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/memoria_sync.sv
// Word-addressed data memory with byte enables, valid/ready handshake and a
// post-reset clear sequencer; out-of-range accesses return an error response.
module memoria_sync
  import memoria_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = 32,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Req_valid,
  output logic                   Req_ready,
  input  logic                   Req_write,
  input  logic [ADDR_W-1:0]      Address,
  input  logic [DATA_W-1:0]      WriteData,
  input  logic [DATA_W/8-1:0]    ByteEn,
  output logic                   Resp_valid,
  input  logic                   Resp_ready,
  output logic [DATA_W-1:0]      ReadData,
  output logic                   Resp_error,
  output logic                   Busy
);

  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int AW     = clog2(DEPTH);

  state_t            state;
  logic [AW-1:0]     cnt;
  logic              resp_load;
  logic              accept;
  logic              in_range;
  logic [NBYTES-1:0] ram_we;
  logic              ram_re;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // The full address is compared, so high garbage bits can never alias into storage.
  assign in_range  = (Address < ADDR_W'(DEPTH));
  assign Busy      = (state == ST_CLEAR);
  assign Req_ready = Reset_n && (state == ST_RUN) && (!Resp_valid || Resp_ready);
  assign accept    = Req_valid && Req_ready;
  assign ReadData  = resp_load ? ram_rdata : '0;

  // The RAM port is owned by the clear sequencer until it hands over to RUN.
  always_comb begin
    ram_we    = '0;
    ram_re    = 1'b0;
    ram_addr  = Address[AW-1:0];
    ram_wdata = WriteData;
    if (state == ST_CLEAR) begin
      ram_we    = '1;
      ram_addr  = cnt;
      ram_wdata = '0;
    end else if (accept && in_range) begin
      if (Req_write) ram_we = ByteEn;
      else           ram_re = 1'b1;
    end
  end

  memoria_sync_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NB     (NBYTES),
    .AW     (AW)
  ) u_ram (
    .clk   (Clock),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Sequencer plus single-entry response register; a consume and a new accept
  // in the same cycle simply reload the register without a bubble.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= INIT_CLEAR ? ST_CLEAR : ST_RUN;
      cnt        <= '0;
      Resp_valid <= 1'b0;
      Resp_error <= 1'b0;
      resp_load  <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(DEPTH - 1)) state <= ST_RUN;
        end
        ST_RUN: begin
          if (accept) begin
            Resp_valid <= 1'b1;
            Resp_error <= !in_range;
            resp_load  <= !Req_write && in_range;
          end else if (Resp_ready) begin
            Resp_valid <= 1'b0;
            Resp_error <= 1'b0;
            resp_load  <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_memoria_sync.sv
// Scoreboard bench for memoria_sync: stimulus pushes expected responses,
// a negedge monitor pops and compares every consumed response.
module tb_memoria_sync;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } resp_t;

  logic                Clock = 1'b0;
  logic                Reset_n = 1'b0;
  logic                Req_valid = 1'b0;
  logic                Req_ready;
  logic                Req_write = 1'b0;
  logic [ADDR_W-1:0]   Address = '0;
  logic [DATA_W-1:0]   WriteData = '0;
  logic [DATA_W/8-1:0] ByteEn = '0;
  logic                Resp_valid;
  logic                Resp_ready = 1'b1;
  logic [DATA_W-1:0]   ReadData;
  logic                Resp_error;
  logic                Busy;

  int    errors = 0;
  int    checks = 0;
  resp_t expq[$];

  memoria_sync #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .INIT_CLEAR (1'b1)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Req_valid  (Req_valid),
    .Req_ready  (Req_ready),
    .Req_write  (Req_write),
    .Address    (Address),
    .WriteData  (WriteData),
    .ByteEn     (ByteEn),
    .Resp_valid (Resp_valid),
    .Resp_ready (Resp_ready),
    .ReadData   (ReadData),
    .Resp_error (Resp_error),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every negedge where a response is being consumed is compared.
  always @(negedge Clock) begin
    if (Reset_n && Resp_valid && Resp_ready) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = expq.pop_front();
        checkOutput("resp_data", ReadData, e.data);
        checkOutput("resp_error", {31'd0, Resp_error}, {31'd0, e.err});
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wd, input logic [3:0] be,
                               input logic [DATA_W-1:0] exp_data, input logic exp_err);
    bit got_it;
    resp_t e;
    got_it    = 0;
    Req_valid = 1'b1;
    Req_write = wr;
    Address   = addr;
    WriteData = wd;
    ByteEn    = be;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (Req_ready) begin
        got_it = 1;
        break;
      end
      @(posedge Clock); #1;
    end
    if (!got_it) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      Req_valid = 1'b0;
    end else begin
      e.data = exp_data;
      e.err  = exp_err;
      expq.push_back(e);
      @(posedge Clock); #1;
      Req_valid = 1'b0;
      @(negedge Clock);
      checkOutput("latency_valid", {31'd0, Resp_valid}, 32'd1);
      @(posedge Clock); #1;
    end
  endtask

  task automatic waitClear(output int n, output int rdy_hi);
    n = 0;
    rdy_hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (!Busy) break;
      n++;
      if (Req_ready) rdy_hi++;
    end
    @(posedge Clock); #1;
  endtask

  initial begin
    int n, rdy_hi;
    logic [DATA_W-1:0] held;

    #12;
    checkOutput("rst_busy", {31'd0, Busy}, 32'd1);
    checkOutput("rst_req_ready", {31'd0, Req_ready}, 32'd0);
    checkOutput("rst_resp_valid", {31'd0, Resp_valid}, 32'd0);
    checkOutput("rst_read_data", ReadData, 32'd0);
    checkOutput("rst_resp_error", {31'd0, Resp_error}, 32'd0);

    @(posedge Clock); #1;
    Reset_n = 1'b1;
    repeat (7) @(posedge Clock);
    #1;
    Reset_n = 1'b0;
    #1;
    checkOutput("midclear_busy", {31'd0, Busy}, 32'd1);
    checkOutput("midclear_req_ready", {31'd0, Req_ready}, 32'd0);
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    waitClear(n, rdy_hi);
    checkOutput("clear_cycles", n, DEPTH);
    checkOutput("clear_req_ready", rdy_hi, 32'd0);

    applyStimulus(1'b0, 32'd5, '0, 4'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'd3, 32'hAABBCCDD, 4'b1111, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'd3, 32'h11223344, 4'b0101, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'd3, '0, 4'h0, 32'hAA22CC44, 1'b0);
    applyStimulus(1'b1, 32'd50, 32'h0000007E, 4'b0001, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'd50, '0, 4'h0, 32'h0000007E, 1'b0);

    applyStimulus(1'b1, 32'd0, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
    applyStimulus(1'b1, DEPTH, 32'h12345678, 4'b1111, 32'h0, 1'b1);
    applyStimulus(1'b0, DEPTH, '0, 4'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'hFFFFFFFF, '0, 4'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'd0, '0, 4'h0, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 32'd63, '0, 4'h0, 32'h0, 1'b0);

    applyStimulus(1'b1, 32'd3, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'd3, '0, 4'h0, 32'hAA22CC44, 1'b0);

    // Backpressure: hold the response, then consume and accept in the same cycle.
    Resp_ready = 1'b0;
    Req_valid  = 1'b1;
    Req_write  = 1'b0;
    Address    = 32'd50;
    @(negedge Clock);
    checkOutput("hold_first_ready", {31'd0, Req_ready}, 32'd1);
    expq.push_back('{data: 32'h0000007E, err: 1'b0});
    @(posedge Clock); #1;
    Address = 32'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      if (i == 0) held = ReadData;
      checkOutput("hold_valid", {31'd0, Resp_valid}, 32'd1);
      checkOutput("hold_data", ReadData, 32'h0000007E);
      checkOutput("hold_stable", ReadData, held);
      checkOutput("hold_req_ready", {31'd0, Req_ready}, 32'd0);
    end
    @(posedge Clock); #1;
    Resp_ready = 1'b1;
    @(negedge Clock);
    checkOutput("b2b_req_ready", {31'd0, Req_ready}, 32'd1);
    expq.push_back('{data: 32'hAA22CC44, err: 1'b0});
    @(posedge Clock); #1;
    Req_valid = 1'b0;
    @(negedge Clock);
    checkOutput("b2b_no_bubble", {31'd0, Resp_valid}, 32'd1);
    @(posedge Clock); #1;
    @(posedge Clock); #1;

    // Reset with a response pending: it is dropped and the memory is cleared again.
    Resp_ready = 1'b0;
    Req_valid  = 1'b1;
    Req_write  = 1'b0;
    Address    = 32'd0;
    @(posedge Clock); #1;
    Req_valid = 1'b0;
    checkOutput("pending_valid", {31'd0, Resp_valid}, 32'd1);
    Reset_n = 1'b0;
    #1;
    checkOutput("rst_drop_valid", {31'd0, Resp_valid}, 32'd0);
    Resp_ready = 1'b1;
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    waitClear(n, rdy_hi);
    checkOutput("reclear_cycles", n, DEPTH);
    checkOutput("reclear_req_ready", rdy_hi, 32'd0);
    applyStimulus(1'b0, 32'd0, '0, 4'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'd3, '0, 4'h0, 32'h0, 1'b0);

    repeat (3) @(posedge Clock);
    #1;
    checkOutput("queue_drained", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
